// File: rtl/matmul_stream_out.sv
// Captures a flat batched matmul result and streams it out one element per beat
// over a valid/ready handshake. Optional abort input: define MATMUL_STREAM_ABORT_EN.
module matmul_stream_out #(
  parameter int DATA_WIDTH     = 8,
  parameter int MATMUL_NUM     = 12,
  parameter int OUTPUT_SHAPE_1 = 128,
  parameter int OUTPUT_SHAPE_2 = 128,
  localparam int MUL_W = DATA_WIDTH * MATMUL_NUM * OUTPUT_SHAPE_1 * OUTPUT_SHAPE_2,
  localparam int B_W   = (MATMUL_NUM > 1) ? $clog2(MATMUL_NUM) : 1,
  localparam int R_W   = (OUTPUT_SHAPE_1 > 1) ? $clog2(OUTPUT_SHAPE_1) : 1,
  localparam int C_W   = (OUTPUT_SHAPE_2 > 1) ? $clog2(OUTPUT_SHAPE_2) : 1
) (
  input  logic                         clk_p,
  input  logic                         rst_n,
  input  logic                         start,
`ifdef MATMUL_STREAM_ABORT_EN
  input  logic                         abort,
`endif
  input  logic signed [MUL_W-1:0]      mul,
  output logic                         busy,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [B_W-1:0]               out_batch,
  output logic [R_W-1:0]               out_row,
  output logic [C_W-1:0]               out_col,
  output logic                         out_last,
  output logic                         done
);

  localparam int TOTAL = MATMUL_NUM * OUTPUT_SHAPE_1 * OUTPUT_SHAPE_2;
  localparam int E_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [B_W-1:0] B_MAX = B_W'(MATMUL_NUM - 1);
  localparam logic [R_W-1:0] R_MAX = R_W'(OUTPUT_SHAPE_1 - 1);
  localparam logic [C_W-1:0] C_MAX = C_W'(OUTPUT_SHAPE_2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t           state, state_next;
  logic [MUL_W-1:0] buffer;
  logic [B_W-1:0]   b_cnt;
  logic [R_W-1:0]   r_cnt;
  logic [C_W-1:0]   c_cnt;
  logic [E_W-1:0]   elem;
  logic             accept;
  logic             is_last;
  logic             abort_hit;
  int               sel_base;

  assign accept  = (state == ST_STREAM) && out_ready;
  assign is_last = (b_cnt == B_MAX) && (r_cnt == R_MAX) && (c_cnt == C_MAX);

`ifdef MATMUL_STREAM_ABORT_EN
  assign abort_hit = (state == ST_STREAM) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_p) begin
    if (rst_n) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (start) state_next = ST_STREAM;
      ST_STREAM: begin
        if (abort_hit)              state_next = ST_IDLE;
        else if (accept && is_last) state_next = ST_DONE;
      end
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Counters sit at zero whenever the next cycle is not streaming, so a fresh
  // capture always starts at element (0,0,0) and idle indices read as zero.
  always_ff @(posedge clk_p) begin
    if (rst_n || (state_next != ST_STREAM)) begin
      b_cnt <= '0;
      r_cnt <= '0;
      c_cnt <= '0;
      elem  <= '0;
    end else if (accept) begin
      elem <= elem + 1'b1;
      if (c_cnt == C_MAX) begin
        c_cnt <= '0;
        if (r_cnt == R_MAX) begin
          r_cnt <= '0;
          b_cnt <= b_cnt + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        c_cnt <= c_cnt + 1'b1;
      end
    end
  end

  // NOTE: the capture buffer is deliberately not reset; it is only read after a
  // fresh capture, so clearing it would cost a reset net on every bit for nothing.
  always_ff @(posedge clk_p) begin
    if (!rst_n && (state == ST_IDLE) && start) buffer <= mul;
  end

  always_comb begin
    sel_base = int'(elem) * DATA_WIDTH;
    out_data = '0;
    if (state == ST_STREAM) out_data = buffer[sel_base +: DATA_WIDTH];
  end

  assign out_valid = (state == ST_STREAM);
  assign out_last  = out_valid && is_last;
  assign out_batch = b_cnt;
  assign out_row   = r_cnt;
  assign out_col   = c_cnt;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_matmul_stream_out.sv
// Directed bench for matmul_stream_out: a 2x2x2 batch plus a 1x1x1 degenerate instance.
// Abort checks are built only when MATMUL_STREAM_ABORT_EN is defined.
module tb_matmul_stream_out;

  typedef struct {
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       b;
    logic       r;
    logic       c;
    logic       last;
    logic       done;
    logic       busy;
  } vec_t;

  localparam logic [63:0] MUL_SEQ = 64'h0807060504030201;

  logic        clk = 1'b0;
  logic        rst_n, start, out_ready;
  logic [63:0] mul;
  logic        busy, out_valid, out_last, done;
  logic [7:0]  out_data;
  logic        out_batch, out_row, out_col;

  logic        start1, out_ready1;
  logic [7:0]  mul1;
  logic        busy1, out_valid1, out_last1, done1;
  logic [7:0]  out_data1;
  logic        out_batch1, out_row1, out_col1;

`ifdef MATMUL_STREAM_ABORT_EN
  logic abort, abort1;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  matmul_stream_out #(
    .DATA_WIDTH(8), .MATMUL_NUM(2), .OUTPUT_SHAPE_1(2), .OUTPUT_SHAPE_2(2)
  ) u_dut (
    .clk_p(clk), .rst_n(rst_n), .start(start),
`ifdef MATMUL_STREAM_ABORT_EN
    .abort(abort),
`endif
    .mul(mul), .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_batch(out_batch), .out_row(out_row),
    .out_col(out_col), .out_last(out_last), .done(done)
  );

  matmul_stream_out #(
    .DATA_WIDTH(8), .MATMUL_NUM(1), .OUTPUT_SHAPE_1(1), .OUTPUT_SHAPE_2(1)
  ) u_dut1 (
    .clk_p(clk), .rst_n(rst_n), .start(start1),
`ifdef MATMUL_STREAM_ABORT_EN
    .abort(abort1),
`endif
    .mul(mul1), .busy(busy1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_batch(out_batch1), .out_row(out_row1),
    .out_col(out_col1), .out_last(out_last1), .done(done1)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rd, input logic v, input logic [7:0] d, input logic b,
                     input logic r, input logic c, input logic l, input logic dn, input logic bs);
    vec_t t;
    t.ready = rd; t.valid = v; t.data = d; t.b = b; t.r = r; t.c = c;
    t.last = l; t.done = dn; t.busy = bs;
    vecs.push_back(t);
  endtask

  // Applies vecs[lo..hi], one per cycle, comparing outputs before each edge.
  task automatic run_table(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      out_ready = vecs[i].ready;
      #0;
      check($sformatf("%s[%0d].valid", tag, i), {31'd0, out_valid}, {31'd0, vecs[i].valid});
      check($sformatf("%s[%0d].data", tag, i), {24'd0, out_data}, {24'd0, vecs[i].data});
      check($sformatf("%s[%0d].idx", tag, i), {29'd0, out_batch, out_row, out_col},
            {29'd0, vecs[i].b, vecs[i].r, vecs[i].c});
      check($sformatf("%s[%0d].last", tag, i), {31'd0, out_last}, {31'd0, vecs[i].last});
      check($sformatf("%s[%0d].done", tag, i), {31'd0, done}, {31'd0, vecs[i].done});
      check($sformatf("%s[%0d].busy", tag, i), {31'd0, busy}, {31'd0, vecs[i].busy});
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".busy"},  {31'd0, busy}, 32'd0);
    check({tag, ".done"},  {31'd0, done}, 32'd0);
    check({tag, ".last"},  {31'd0, out_last}, 32'd0);
    check({tag, ".data"},  {24'd0, out_data}, 32'd0);
    check({tag, ".idx"},   {29'd0, out_batch, out_row, out_col}, 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Full-throughput stream: 8 beats, last on 08, done one cycle later.
    add(1,1,8'h01,0,0,0,0,0,1); add(1,1,8'h02,0,0,1,0,0,1);
    add(1,1,8'h03,0,1,0,0,0,1); add(1,1,8'h04,0,1,1,0,0,1);
    add(1,1,8'h05,1,0,0,0,0,1); add(1,1,8'h06,1,0,1,0,0,1);
    add(1,1,8'h07,1,1,0,0,0,1); add(1,1,8'h08,1,1,1,1,0,1);
    add(1,0,8'h00,0,0,0,0,1,1); add(1,0,8'h00,0,0,0,0,0,0);
    // Ready toggling 1,0,1,0: each element held while ready is low.
    add(1,1,8'h01,0,0,0,0,0,1);
    add(0,1,8'h02,0,0,1,0,0,1); add(1,1,8'h02,0,0,1,0,0,1);
    add(0,1,8'h03,0,1,0,0,0,1); add(1,1,8'h03,0,1,0,0,0,1);
    add(0,1,8'h04,0,1,1,0,0,1); add(1,1,8'h04,0,1,1,0,0,1);
    add(0,1,8'h05,1,0,0,0,0,1); add(1,1,8'h05,1,0,0,0,0,1);
    add(0,1,8'h06,1,0,1,0,0,1); add(1,1,8'h06,1,0,1,0,0,1);
    add(0,1,8'h07,1,1,0,0,0,1); add(1,1,8'h07,1,1,0,0,0,1);
    add(0,1,8'h08,1,1,1,1,0,1); add(1,1,8'h08,1,1,1,1,0,1);
    add(1,0,8'h00,0,0,0,0,1,1); add(1,0,8'h00,0,0,0,0,0,0);

    rst_n = 1'b1; start = 1'b0; out_ready = 1'b0; mul = MUL_SEQ;
    start1 = 1'b0; out_ready1 = 1'b0; mul1 = 8'h80;
`ifdef MATMUL_STREAM_ABORT_EN
    abort = 1'b0; abort1 = 1'b0;
`endif
    #1;
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b0;
    step();

    pulse_start();
    run_table(0, 9, "burst");

    pulse_start();
    run_table(10, 26, "toggle");

    // Second start and new mul mid-stream must not disturb the captured data.
    out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin start = 1'b1; mul = '1; end
      if (k == 6) start = 1'b0;
      check($sformatf("recapture.data%0d", k), {24'd0, out_data}, 32'(k + 1));
      step();
    end
    check("recapture.done", {31'd0, done}, 32'd1);
    step();
    check("recapture.idle", {30'd0, busy, out_valid}, 32'd0);
    mul = MUL_SEQ;

    // Reset after three accepted beats, with start held high during reset.
    pulse_start();
    step(); step(); step();
    check("midrst.pre", {24'd0, out_data}, 32'h04);
    rst_n = 1'b1; start = 1'b1;
    step();
    check_all_zero("midrst");
    rst_n = 1'b0; start = 1'b0;
    step();
    check_all_zero("midrst.after");
    pulse_start();
    check("midrst.restart.data", {24'd0, out_data}, 32'h01);
    check("midrst.restart.idx", {29'd0, out_batch, out_row, out_col}, 32'd0);
    for (int k = 0; k < 8; k++) step();
    check("midrst.restart.done", {31'd0, done}, 32'd1);
    step();

    // Single-element batch: first beat is also the last.
    out_ready1 = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("deg.valid", {31'd0, out_valid1}, 32'd1);
    check("deg.data", {24'd0, out_data1}, 32'h80);
    check("deg.last", {31'd0, out_last1}, 32'd1);
    check("deg.idx", {29'd0, out_batch1, out_row1, out_col1}, 32'd0);
    step();
    check("deg.done", {30'd0, done1, out_valid1}, 32'd2);
    step();
    check("deg.idle", {30'd0, done1, busy1}, 32'd0);

`ifdef MATMUL_STREAM_ABORT_EN
    // Abort after two beats, asserted together with ready to test priority.
    out_ready = 1'b1;
    pulse_start();
    step(); step();
    check("abort.pre", {24'd0, out_data}, 32'h03);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_all_zero("abort");
    step();
    check("abort.nodone", {31'd0, done}, 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort.idle_noeffect", {31'd0, busy}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
